// File: rtl/bsg_manycore_link_to_crossbar_buffered.sv
// bsg_manycore_link_to_crossbar_buffered: FIFO-buffered bridge between a manycore link array and a flat crossbar port vector
// Each link word is packed as {data[width_p-1:0], v, ready_and_rev}.
module bsg_manycore_link_to_crossbar_buffered_fifo #(
  parameter int width_p = 8,
  parameter int els_p = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic enq_i,
  input  logic deq_i,
  output logic full_o,
  output logic v_o,
  output logic [width_p-1:0] data_o
);
  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);
  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0] rd, wr;
  logic [cnt_w-1:0] cnt;
  always_ff @(posedge clk_i)
    if (enq_i) mem[wr] <= data_i;
  always_ff @(posedge clk_i)
    if (reset_i) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      if (enq_i) wr <= (wr == ptr_w'(els_p - 1)) ? '0 : wr + 1'b1;
      if (deq_i) rd <= (rd == ptr_w'(els_p - 1)) ? '0 : rd + 1'b1;
      cnt <= cnt + cnt_w'(enq_i) - cnt_w'(deq_i);
    end
  assign full_o = cnt == cnt_w'(els_p);
  assign v_o = cnt != '0;
  assign data_o = mem[rd];
endmodule

module bsg_manycore_link_to_crossbar_buffered #(
  parameter int width_p = 16,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int num_in_x_p = 2,
  parameter int num_in_y_p = 2,
  parameter int origin_x_p = 0,
  parameter int origin_y_p = 0,
  parameter int in_fifo_els_p = 2,
  parameter int out_fifo_els_p = 2,
  parameter int use_credits_p = 0,
  parameter int credit_max_p = 4,
  localparam int num_in_lp = num_in_x_p * num_in_y_p,
  localparam int lg_num_in_lp = (num_in_lp > 1) ? $clog2(num_in_lp) : 1,
  localparam int xbar_width_lp = width_p - x_cord_width_p - y_cord_width_p + lg_num_in_lp
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [num_in_y_p-1:0][num_in_x_p-1:0][width_p+1:0] links_sif_i,
  output logic [num_in_y_p-1:0][num_in_x_p-1:0][width_p+1:0] links_sif_o,
  output logic [num_in_lp-1:0] valid_o,
  output logic [num_in_lp-1:0][xbar_width_lp-1:0] data_o,
  input  logic [num_in_lp-1:0] credit_or_ready_i,
  input  logic [num_in_lp-1:0] valid_i,
  input  logic [num_in_lp-1:0][xbar_width_lp-1:0] data_i,
  output logic [num_in_lp-1:0] ready_and_o,
  output logic [num_in_lp-1:0] oob_err_o
);
  localparam int cord_w = x_cord_width_p + y_cord_width_p;
  localparam int xl_w = x_cord_width_p + 1;
  localparam int yl_w = y_cord_width_p + 1;
  localparam int cred_w = $clog2(credit_max_p + 1);
  for (genvar i = 0; i < num_in_y_p; i++) begin : row
    for (genvar j = 0; j < num_in_x_p; j++) begin : col
      localparam int p = i * num_in_x_p + j;
      logic in_full, in_v, in_ready, in_deq, in_range, fire, oob;
      logic out_full, out_v, out_ready;
      logic [width_p-1:0] in_data;
      logic [xbar_width_lp-1:0] out_data;
      logic [xl_w-1:0] lx;
      logic [yl_w-1:0] ly;
      logic [lg_num_in_lp-1:0] out_idx;
      assign in_ready = ~in_full & ~reset_i;
      bsg_manycore_link_to_crossbar_buffered_fifo #(.width_p(width_p), .els_p(in_fifo_els_p)) in_fifo (
        .clk_i, .reset_i,
        .data_i(links_sif_i[i][j][width_p+1:2]),
        .enq_i(links_sif_i[i][j][1] & in_ready),
        .deq_i(in_deq),
        .full_o(in_full),
        .v_o(in_v),
        .data_o(in_data)
      );
      // widened subtract: the top bit is the borrow for destinations left of / below the origin
      assign lx = {1'b0, in_data[x_cord_width_p-1:0]} - xl_w'(origin_x_p);
      assign ly = {1'b0, in_data[cord_w-1:x_cord_width_p]} - yl_w'(origin_y_p);
      assign in_range = ~lx[xl_w-1] & ~ly[yl_w-1]
                      & (32'(lx[x_cord_width_p-1:0]) < num_in_x_p)
                      & (32'(ly[y_cord_width_p-1:0]) < num_in_y_p);
      assign data_o[p] = {in_data[width_p-1:cord_w],
                          lg_num_in_lp'(32'(ly[y_cord_width_p-1:0]) * num_in_x_p + 32'(lx[x_cord_width_p-1:0]))};
      assign in_deq = fire | (in_v & ~in_range);
      if (use_credits_p != 0) begin : credit
        logic [cred_w-1:0] cred;
        logic cr_ok;
        assign valid_o[p] = in_v & in_range & (cred != '0);
        assign fire = valid_o[p];
        assign cr_ok = credit_or_ready_i[p] & (cred != cred_w'(credit_max_p));
        always_ff @(posedge clk_i)
          if (reset_i) cred <= cred_w'(credit_max_p);
          else cred <= cred + cred_w'(cr_ok) - cred_w'(fire);
        assert property (@(posedge clk_i) disable iff (reset_i)
          !(credit_or_ready_i[p] && cred == cred_w'(credit_max_p)))
          else $error("credit overflow on port %0d", p);
      end else begin : ready
        assign valid_o[p] = in_v & in_range;
        assign fire = valid_o[p] & credit_or_ready_i[p];
      end
      always_ff @(posedge clk_i)
        if (reset_i) oob <= 1'b0;
        else if (in_v & ~in_range) oob <= 1'b1;
      assign oob_err_o[p] = oob;
      assign out_ready = ~out_full & ~reset_i;
      assign ready_and_o[p] = out_ready;
      bsg_manycore_link_to_crossbar_buffered_fifo #(.width_p(xbar_width_lp), .els_p(out_fifo_els_p)) out_fifo (
        .clk_i, .reset_i,
        .data_i(data_i[p]),
        .enq_i(valid_i[p] & out_ready),
        .deq_i(out_v & links_sif_i[i][j][0]),
        .full_o(out_full),
        .v_o(out_v),
        .data_o(out_data)
      );
      assign out_idx = out_data[lg_num_in_lp-1:0];
      assign links_sif_o[i][j] = {out_data[xbar_width_lp-1:lg_num_in_lp],
                                  y_cord_width_p'(32'(out_idx) / num_in_x_p + origin_y_p),
                                  x_cord_width_p'(32'(out_idx) % num_in_x_p + origin_x_p),
                                  out_v, in_ready};
    end
  end
endmodule

// File: tb/tb_bsg_manycore_link_to_crossbar_buffered.sv
// tb_bsg_manycore_link_to_crossbar_buffered: scoreboard bench; A = 4x2 ready mode origin (1,1), B = 2x2 credit mode origin (4,8)
module tb_bsg_manycore_link_to_crossbar_buffered;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [7:0] a_v, a_rr, va_o, cr_a, vi_a, rdy_a, oob_a;
  logic [15:0] a_d [8];
  logic [1:0][3:0][17:0] la_i, la_o;
  logic [7:0][10:0] da_o, di_a;
  logic [3:0] b_v, b_rr, vb_o, cr_b, vi_b, rdy_b, oob_b;
  logic [15:0] b_d [4];
  logic [1:0][1:0][17:0] lb_i, lb_o;
  logic [3:0][9:0] db_o, di_b;
  int checks = 0;
  int errors = 0;
  int fires_b [4] = '{0, 0, 0, 0};
  logic [10:0] qa [8][$];
  logic [15:0] qe [8][$];
  logic [9:0] qb [4][$];
  logic [15:0] qbe [4][$];
  always_comb begin
    la_i = '0;
    lb_i = '0;
    for (int p = 0; p < 8; p++) la_i[p/4][p%4] = {a_d[p], a_v[p], a_rr[p]};
    for (int p = 0; p < 4; p++) lb_i[p/2][p%2] = {b_d[p], b_v[p], b_rr[p]};
  end
  bsg_manycore_link_to_crossbar_buffered #(
    .width_p(16), .x_cord_width_p(4), .y_cord_width_p(4), .num_in_x_p(4), .num_in_y_p(2),
    .origin_x_p(1), .origin_y_p(1), .in_fifo_els_p(2), .out_fifo_els_p(2), .use_credits_p(0), .credit_max_p(4)
  ) dut_a (
    .clk_i(clk), .reset_i(rst), .links_sif_i(la_i), .links_sif_o(la_o), .valid_o(va_o), .data_o(da_o),
    .credit_or_ready_i(cr_a), .valid_i(vi_a), .data_i(di_a), .ready_and_o(rdy_a), .oob_err_o(oob_a)
  );
  bsg_manycore_link_to_crossbar_buffered #(
    .width_p(16), .x_cord_width_p(4), .y_cord_width_p(4), .num_in_x_p(2), .num_in_y_p(2),
    .origin_x_p(4), .origin_y_p(8), .in_fifo_els_p(2), .out_fifo_els_p(2), .use_credits_p(1), .credit_max_p(2)
  ) dut_b (
    .clk_i(clk), .reset_i(rst), .links_sif_i(lb_i), .links_sif_o(lb_o), .valid_o(vb_o), .data_o(db_o),
    .credit_or_ready_i(cr_b), .valid_i(vi_b), .data_i(di_b), .ready_and_o(rdy_b), .oob_err_o(oob_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] a_bits(input int b);
    logic [7:0] r = '0;
    for (int p = 0; p < 8; p++) r[p] = la_o[p/4][p%4][b];
    return r;
  endfunction
  function automatic logic [3:0] b_bits(input int b);
    logic [3:0] r = '0;
    for (int p = 0; p < 4; p++) r[p] = lb_o[p/2][p%2][b];
    return r;
  endfunction
  function automatic int pending();
    int s = 0;
    for (int p = 0; p < 8; p++) s += qa[p].size() + qe[p].size();
    for (int p = 0; p < 4; p++) s += qb[p].size() + qbe[p].size();
    return s;
  endfunction
  task automatic send_a(input int p, input int x, input int y, input logic [7:0] pl);
    int n = 0;
    a_d[p] = {pl, 4'(y), 4'(x)};
    a_v[p] = 1'b1;
    while (!la_o[p/4][p%4][0] && n < 50) begin step(); n++; end
    chk("a_in_wait", 32'(n < 50), 1);
    if (x >= 1 && x <= 4 && y >= 1 && y <= 2) qa[p].push_back({pl, 3'((y - 1) * 4 + (x - 1))});
    step();
    a_v[p] = 1'b0;
  endtask
  task automatic send_b(input int p, input int x, input int y, input logic [7:0] pl);
    int n = 0;
    b_d[p] = {pl, 4'(y), 4'(x)};
    b_v[p] = 1'b1;
    while (!lb_o[p/2][p%2][0] && n < 50) begin step(); n++; end
    chk("b_in_wait", 32'(n < 50), 1);
    if (x >= 4 && x <= 5 && y >= 8 && y <= 9) qb[p].push_back({pl, 2'((y - 8) * 2 + (x - 4))});
    step();
    b_v[p] = 1'b0;
  endtask
  task automatic send_e(input int p, input int idx, input logic [7:0] pl);
    int n = 0;
    di_a[p] = {pl, 3'(idx)};
    vi_a[p] = 1'b1;
    while (!rdy_a[p] && n < 50) begin step(); n++; end
    chk("a_out_wait", 32'(n < 50), 1);
    qe[p].push_back({pl, 4'(idx / 4 + 1), 4'(idx % 4 + 1)});
    step();
    vi_a[p] = 1'b0;
  endtask
  always @(negedge clk) if (!rst) begin
    for (int p = 0; p < 8; p++) begin
      if (va_o[p] && cr_a[p]) begin
        chk("a_xbar_expected", 32'(qa[p].size() != 0), 1);
        if (qa[p].size() != 0) chk("a_xbar_data", 32'(da_o[p]), 32'(qa[p].pop_front()));
      end
      if (la_o[p/4][p%4][1] && a_rr[p]) begin
        chk("a_link_expected", 32'(qe[p].size() != 0), 1);
        if (qe[p].size() != 0) chk("a_link_data", 32'(la_o[p/4][p%4][17:2]), 32'(qe[p].pop_front()));
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (vb_o[p]) begin
        fires_b[p]++;
        chk("b_xbar_expected", 32'(qb[p].size() != 0), 1);
        if (qb[p].size() != 0) chk("b_xbar_data", 32'(db_o[p]), 32'(qb[p].pop_front()));
      end
      if (lb_o[p/2][p%2][1] && b_rr[p]) begin
        chk("b_link_expected", 32'(qbe[p].size() != 0), 1);
        if (qbe[p].size() != 0) chk("b_link_data", 32'(lb_o[p/2][p%2][17:2]), 32'(qbe[p].pop_front()));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int f0;
    rst = 1'b1;
    a_v = '0; a_rr = '1; cr_a = '1; vi_a = '0; di_a = '0;
    b_v = '0; b_rr = '1; cr_b = '0; vi_b = '0; di_b = '0;
    for (int p = 0; p < 8; p++) a_d[p] = '0;
    for (int p = 0; p < 4; p++) b_d[p] = '0;
    repeat (3) step();
    chk("rst_a_ready_and", 32'(rdy_a), 0);
    chk("rst_a_link_ready", 32'(a_bits(0)), 0);
    chk("rst_a_link_v", 32'(a_bits(1)), 0);
    chk("rst_a_valid", 32'(va_o), 0);
    chk("rst_b_ready_and", 32'(rdy_b), 0);
    chk("rst_b_valid", 32'(vb_o), 0);
    chk("rst_oob", 32'({oob_a, oob_b}), 0);
    rst = 1'b0;
    step();
    chk("post_rst_a_ready", 32'({a_bits(0), rdy_a}), 32'hffff);
    chk("post_rst_b_ready", 32'({b_bits(0), rdy_b}), 32'hff);
    send_a(0, 2, 2, 8'ha5);
    chk("a_latency_valid", 32'(va_o[0]), 1);
    chk("a_latency_data", 32'(da_o[0]), 32'({8'ha5, 3'd5}));
    send_a(3, 1, 1, 8'h3c);
    send_a(5, 4, 2, 8'h77);
    step();
    chk("a_oob_none", 32'(oob_a), 0);
    send_a(2, 5, 1, 8'h01);
    send_a(6, 0, 1, 8'h02);
    send_a(7, 1, 3, 8'h03);
    send_a(1, 1, 0, 8'h04);
    step(); step();
    chk("a_oob_flags", 32'(oob_a), 32'hc6);
    chk("a_oob_no_valid", 32'(va_o), 0);
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < 8; p++) begin
        a_d[p] = {3'(p), 5'(k), 4'(1 + k % 2), 4'(1 + (k + p) % 4)};
        a_v[p] = 1'b1;
        qa[p].push_back({3'(p), 5'(k), 3'((k % 2) * 4 + (k + p) % 4)});
      end
      chk("b2b_ready", 32'(a_bits(0)), 32'hff);
      step();
    end
    a_v = '0;
    step(); step();
    chk("b2b_drained", pending(), 0);
    a_rr[5] = 1'b0;
    send_e(5, 5, 8'hd1);
    chk("e_latency_v", 32'(la_o[1][1][1]), 1);
    send_e(5, 6, 8'hd2);
    chk("e_full_ready", 32'(rdy_a[5]), 0);
    step();
    chk("e_hold_ready", 32'({rdy_a[5], la_o[1][1][1]}), 1);
    step();
    a_rr[5] = 1'b1;
    send_e(5, 7, 8'hd3);
    send_e(0, 0, 8'he0);
    di_b[2] = {8'hb7, 2'd3};
    vi_b[2] = 1'b1;
    qbe[2].push_back({8'hb7, 4'd9, 4'd5});
    step();
    vi_b[2] = 1'b0;
    repeat (3) step();
    chk("e_drained", pending(), 0);
    send_b(1, 3, 8, 8'h55);
    step(); step();
    chk("b_oob_flags", 32'(oob_b), 32'h2);
    f0 = fires_b[0];
    send_b(0, 5, 8, 8'h10);
    send_b(0, 5, 8, 8'h11);
    send_b(0, 5, 8, 8'h12);
    send_b(0, 5, 8, 8'h13);
    repeat (3) step();
    chk("cred_two_fired", fires_b[0] - f0, 2);
    chk("cred_fifo_full", 32'({lb_o[0][0][0], vb_o[0]}), 0);
    cr_b[0] = 1'b1;
    step();
    cr_b[0] = 1'b0;
    step(); step();
    chk("cred_pulse_fire", fires_b[0] - f0, 3);
    cr_b[0] = 1'b1;
    step(); step();
    cr_b[0] = 1'b0;
    step();
    chk("cred_fire_and_credit", fires_b[0] - f0, 4);
    send_b(0, 5, 8, 8'h14);
    send_b(0, 5, 8, 8'h15);
    step(); step();
    chk("cred_balance", fires_b[0] - f0, 5);
    chk("cred_exhausted", 32'(vb_o[0]), 0);
    cr_a[4] = 1'b0;
    send_a(4, 2, 1, 8'h44);
    a_rr[6] = 1'b0;
    send_e(6, 3, 8'h66);
    chk("half_full_pending", 32'({va_o[4], la_o[1][2][1]}), 3);
    chk("a_oob_sticky", 32'(oob_a), 32'hc6);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'({va_o, vb_o}), 0);
    chk("mid_rst_link_v", 32'({a_bits(1), b_bits(1)}), 0);
    chk("mid_rst_ready", 32'({rdy_a, rdy_b, a_bits(0), b_bits(0)}), 0);
    rst = 1'b0;
    qa[4].delete();
    qe[6].delete();
    qb[0].delete();
    cr_a = '1;
    a_rr = '1;
    repeat (4) step();
    chk("post_rst_oob", 32'({oob_a, oob_b}), 0);
    f0 = fires_b[0];
    send_b(0, 4, 9, 8'h20);
    send_b(0, 4, 9, 8'h21);
    send_b(0, 4, 9, 8'h22);
    repeat (3) step();
    chk("rst_credits_reload", fires_b[0] - f0, 2);
    chk("rst_credits_stall", 32'(qb[0].size()), 1);
    qb[0].delete();
    chk("final_drained", pending(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
